// File: rtl/ritc_train_pkg.sv
// Shared definitions for the RITC bitslip trainer: controller state codes,
// slip-command field layout and word geometry.
package ritc_train_pkg;

    localparam int NUM_LANES        = 12;
    localparam int SAMPLES_PER_WORD = 4;
    localparam int WORD_W           = NUM_LANES * SAMPLES_PER_WORD;

    localparam int LANE_LSB   = 0;
    localparam int LANE_W     = 4;
    localparam int CHAN_LSB   = 4;
    localparam int CHAN_W     = 3;
    localparam int SLIP_DAT_W = CHAN_W + LANE_W;

    typedef logic [2:0] train_state_t;

    localparam train_state_t ST_IDLE   = 3'd0;
    localparam train_state_t ST_SETTLE = 3'd1;
    localparam train_state_t ST_CHECK  = 3'd2;
    localparam train_state_t ST_SLIP   = 3'd3;
    localparam train_state_t ST_NEXT   = 3'd4;
    localparam train_state_t ST_DONE   = 3'd5;
    localparam train_state_t ST_FAIL   = 3'd6;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/ritc_lane_extract.sv
// Gathers the four samples of one bit lane out of a 48-bit channel word and
// compares the resulting nibble {s3,s2,s1,s0} with the training pattern.
module ritc_lane_extract
    import ritc_train_pkg::*;
#(
    parameter logic [3:0] TRAIN_PATTERN = 4'b0001
)(
    input  logic [WORD_W-1:0] data_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic              match_o
);

    logic [SAMPLES_PER_WORD-1:0] nibble;
    logic                        lane_ok;

    // Sample k of lane L lives at bit 12k+L.
    always_comb begin
        nibble = '0;
        for (int k = 0; k < SAMPLES_PER_WORD; k++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_i == LANE_W'(l)) begin
                    nibble[k] = data_i[NUM_LANES*k + l];
                end
            end
        end
    end

    assign lane_ok = (lane_i < LANE_W'(NUM_LANES));
    assign match_o = lane_ok && (nibble == TRAIN_PATTERN);

endmodule

// File: rtl/ritc_bitslip_trainer.sv
// Per-channel bitslip trainer: walks the 12 lanes, settles, checks the
// training nibble and issues {channel,lane} slip requests until lock or give-up.
module ritc_bitslip_trainer
    import ritc_train_pkg::*;
#(
    parameter int         CHANNEL       = 0,
    parameter logic [3:0] TRAIN_PATTERN = 4'b0001,
    parameter logic [7:0] SETTLE_WORDS  = 8'd16,
    parameter logic [7:0] CHECK_WORDS   = 8'd64,
    parameter int         MAX_SLIPS     = 8
)(
    input  logic        SYSCLK,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [47:0] data_i,
    input  logic        data_valid_i,
    output logic        slip_valid_o,
    output logic [6:0]  slip_dat_o,
    input  logic        slip_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [11:0] lock_mask_o,
    output logic [11:0] fail_mask_o,
    output logic [2:0]  state_dbg_o
);

    localparam logic [CHAN_W-1:0] CHAN_C      = CHAN_W'(CHANNEL);
    localparam logic [3:0]        MAX_SLIPS_C = 4'(MAX_SLIPS);
    localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(NUM_LANES - 1);

    train_state_t         state;
    logic [LANE_W-1:0]    lane;
    logic [3:0]           slips;
    logic [7:0]           settle_cnt;
    logic [7:0]           match_cnt;
    logic [NUM_LANES-1:0] lock_mask;
    logic [NUM_LANES-1:0] fail_mask;

    logic                 lane_match;
    logic                 settle_last;
    logic                 match_last;
    logic [8:0]           settle_next;
    logic [8:0]           match_next;
    logic [NUM_LANES-1:0] lane_bit;

    ritc_lane_extract #(
        .TRAIN_PATTERN (TRAIN_PATTERN)
    ) u_lane_extract (
        .data_i  (data_i),
        .lane_i  (lane),
        .match_o (lane_match)
    );

    // The word that completes a count is the one seen at this edge, hence +1.
    always_comb begin
        settle_next = {1'b0, settle_cnt} + 9'd1;
        match_next  = {1'b0, match_cnt} + 9'd1;
        settle_last = (settle_next >= {1'b0, SETTLE_WORDS});
        match_last  = (match_next >= {1'b0, CHECK_WORDS});
        lane_bit    = NUM_LANES'(1) << lane;
    end

    always_ff @(posedge SYSCLK) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            lane       <= '0;
            slips      <= '0;
            settle_cnt <= '0;
            match_cnt  <= '0;
            lock_mask  <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_i) begin
                        lock_mask  <= '0;
                        fail_mask  <= '0;
                        lane       <= '0;
                        slips      <= '0;
                        settle_cnt <= '0;
                        match_cnt  <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (data_valid_i) begin
                        if (settle_last) begin
                            settle_cnt <= '0;
                            match_cnt  <= '0;
                            state      <= ST_CHECK;
                        end else begin
                            settle_cnt <= sat_inc8(settle_cnt);
                        end
                    end
                end
                ST_CHECK: begin
                    if (data_valid_i) begin
                        if (lane_match) begin
                            if (match_last) begin
                                lock_mask <= lock_mask | lane_bit;
                                state     <= ST_NEXT;
                            end else begin
                                match_cnt <= sat_inc8(match_cnt);
                            end
                        end else if (slips < MAX_SLIPS_C) begin
                            state <= ST_SLIP;
                        end else begin
                            fail_mask <= fail_mask | lane_bit;
                            state     <= ST_NEXT;
                        end
                    end
                end
                ST_SLIP: begin
                    // Request stays up until the bitslip decoder takes it.
                    if (slip_ack_i) begin
                        slips      <= sat_inc4(slips);
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_NEXT: begin
                    if (lane < LAST_LANE) begin
                        lane       <= lane + 4'd1;
                        slips      <= '0;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end else begin
                        state <= (fail_mask == '0) ? ST_DONE : ST_FAIL;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign slip_valid_o = (state == ST_SLIP);
    assign busy_o       = (state == ST_SETTLE) || (state == ST_CHECK) ||
                          (state == ST_SLIP)   || (state == ST_NEXT);
    assign done_o       = (state == ST_DONE);
    assign fail_o       = (state == ST_FAIL);
    assign lock_mask_o  = lock_mask;
    assign fail_mask_o  = fail_mask;
    assign state_dbg_o  = state;

    always_comb begin
        slip_dat_o = '0;
        if (slip_valid_o) begin
            slip_dat_o[CHAN_LSB +: CHAN_W] = CHAN_C;
            slip_dat_o[LANE_LSB +: LANE_W] = lane;
        end
    end

endmodule

// File: tb/tb_ritc_bitslip_trainer.sv
// Directed bench for ritc_bitslip_trainer: a lane data model with per-lane
// rotation, an ack responder, and a monitor checking slip and completion events.
module tb_ritc_bitslip_trainer;
    import ritc_train_pkg::*;

    localparam logic [3:0] PAT = 4'b0001;
    localparam int         CH  = 3;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [47:0] data_i;
    logic        data_valid_i;
    logic        slip_valid_o;
    logic [6:0]  slip_dat_o;
    logic        slip_ack_i;
    logic        busy_o;
    logic        done_o;
    logic        fail_o;
    logic [11:0] lock_mask_o;
    logic [11:0] fail_mask_o;
    logic [2:0]  state_dbg_o;

    always #5 clk = ~clk;

    ritc_bitslip_trainer #(
        .CHANNEL       (CH),
        .TRAIN_PATTERN (PAT),
        .SETTLE_WORDS  (8'd16),
        .CHECK_WORDS   (8'd64),
        .MAX_SLIPS     (8)
    ) dut (
        .SYSCLK       (clk),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .slip_valid_o (slip_valid_o),
        .slip_dat_o   (slip_dat_o),
        .slip_ack_i   (slip_ack_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fail_o       (fail_o),
        .lock_mask_o  (lock_mask_o),
        .fail_mask_o  (fail_mask_o),
        .state_dbg_o  (state_dbg_o)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [6:0]  slip_exp_q[$];
    logic [26:0] res_exp_q[$];   // {busy, done, fail, lock_mask, fail_mask}

    int rot_init[12];
    int slip_cnt[12];
    bit stuck[12];
    bit gate_valid;
    int ack_mode;                // 0 idle, 1 handshake, 2 stray acks
    int ack_delay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rotl4(input logic [3:0] p, input int r);
        logic [7:0] d;
        d = {p, p};
        return d[7 - (r % 4) -: 4];
    endfunction

    // Lane data model; invalid cycles carry the inverted word so any
    // counting of invalid data shows up as a spurious slip.
    initial begin
        logic [3:0]  nib;
        logic [47:0] w;
        int          phase;
        phase        = 0;
        data_i       = '0;
        data_valid_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int l = 0; l < 12; l++) begin
                nib = stuck[l] ? 4'b0000 : rotl4(PAT, rot_init[l] + slip_cnt[l]);
                for (int k = 0; k < 4; k++) w[12*k + l] = nib[k];
            end
            data_valid_i = gate_valid ? (phase == 0) : 1'b1;
            data_i       = data_valid_i ? w : ~w;
            phase        = (phase + 1) % 3;
        end
    end

    // Bitslip decoder stand-in: holds off ack_delay cycles, then acks once.
    initial begin
        logic [3:0] ln;
        bit         have;
        slip_ack_i = 1'b0;
        for (int l = 0; l < 12; l++) slip_cnt[l] = 0;
        forever begin
            @(negedge clk);
            if (ack_mode == 2) begin
                @(posedge clk); #1 slip_ack_i = 1'b1;
                @(posedge clk); #1 slip_ack_i = 1'b0;
            end else if (ack_mode == 1 && slip_valid_o) begin
                have = (slip_exp_q.size() > 0);
                ln   = have ? slip_exp_q[0][3:0] : 4'd0;
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    check("slip_hold_valid", slip_valid_o, 1);
                    if (have) check("slip_hold_dat", slip_dat_o, slip_exp_q[0]);
                end
                @(posedge clk); #1 slip_ack_i = 1'b1;
                @(posedge clk); #1 slip_ack_i = 1'b0;
                if (have && ln < 12) slip_cnt[ln] = slip_cnt[ln] + 1;
            end
        end
    end

    // Monitor: consumed slip requests and run completions.
    initial begin
        logic prev_end;
        logic cur_end;
        prev_end = 1'b0;
        forever begin
            @(negedge clk);
            if (slip_valid_o && slip_ack_i) begin
                n_vec++;
                if (slip_exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL slip_unexpected: got %0h, expected no request", slip_dat_o);
                end else if (slip_dat_o !== slip_exp_q[0]) begin
                    n_err++;
                    $display("FAIL slip_dat: got %0h, expected %0h", slip_dat_o, slip_exp_q[0]);
                    void'(slip_exp_q.pop_front());
                end else begin
                    void'(slip_exp_q.pop_front());
                end
            end
            cur_end = done_o | fail_o;
            if (cur_end && !prev_end) begin
                n_vec++;
                if (res_exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL result_unexpected: got done=%0b fail=%0b", done_o, fail_o);
                end else begin
                    if ({busy_o, done_o, fail_o, lock_mask_o, fail_mask_o} !== res_exp_q[0]) begin
                        n_err++;
                        $display("FAIL result: got %0h, expected %0h",
                                 {busy_o, done_o, fail_o, lock_mask_o, fail_mask_o}, res_exp_q[0]);
                    end
                    void'(res_exp_q.pop_front());
                end
            end
            prev_end = cur_end;
        end
    end

    task automatic start_run();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        check("start_busy", busy_o, 1);
        check("start_done_clr", done_o, 0);
        check("start_fail_clr", fail_o, 0);
        check("start_lock_clr", lock_mask_o, 12'h000);
        check("start_failm_clr", fail_mask_o, 12'h000);
    endtask

    task automatic wait_done(input string name, input int budget, input int c0, output int c);
        bit ok;
        ok = 1'b0;
        c  = c0;
        while (c < budget) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (done_o || fail_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no completion within %0d cycles", name, budget);
        end
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        check({name, "_slip_q_empty"}, slip_exp_q.size(), 0);
        check({name, "_res_q_empty"}, res_exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        int guard;
        rst_n_i    = 1'b0;
        start_i    = 1'b0;
        gate_valid = 1'b0;
        ack_mode   = 1;
        ack_delay  = 3;
        for (int l = 0; l < 12; l++) begin
            rot_init[l] = 0;
            stuck[l]    = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_slip_valid", slip_valid_o, 0);
        check("rst_slip_dat", slip_dat_o, 7'h00);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_fail", fail_o, 0);
        check("rst_lock", lock_mask_o, 12'h000);
        check("rst_failm", fail_mask_o, 12'h000);
        check("rst_state", state_dbg_o, ST_IDLE);
        @(posedge clk); #1 rst_n_i = 1'b1;

        // Clean lanes, continuous valid, with a start pulse mid-run.
        res_exp_q.push_back({1'b0, 1'b1, 1'b0, 12'hFFF, 12'h000});
        start_run();
        repeat (300) @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        check("midrun_lock", lock_mask_o, 12'h007);
        check("midrun_busy", busy_o, 1);
        wait_done("clean", 1200, 301, cyc);
        check("clean_cycles", cyc, 12 * (16 + 64 + 1));
        drain("clean");

        // Lane 5 off by two positions: two slips on {3,5}.
        rot_init[5] = 2;
        slip_exp_q.push_back(7'h35);
        slip_exp_q.push_back(7'h35);
        res_exp_q.push_back({1'b0, 1'b1, 1'b0, 12'hFFF, 12'h000});
        start_run();
        wait_done("lane5_rot", 6000, 0, cyc);
        drain("lane5_rot");

        // Lane 9 stuck low: eight slips then give up.
        ack_delay = 2;
        stuck[9]  = 1'b1;
        for (int i = 0; i < 8; i++) slip_exp_q.push_back(7'h39);
        res_exp_q.push_back({1'b0, 1'b0, 1'b1, 12'hDFF, 12'h200});
        start_run();
        wait_done("lane9_stuck", 6000, 0, cyc);
        drain("lane9_stuck");
        stuck[9] = 1'b0;

        // Valid on one cycle in three, clean lanes.
        gate_valid = 1'b1;
        res_exp_q.push_back({1'b0, 1'b1, 1'b0, 12'hFFF, 12'h000});
        start_run();
        wait_done("gated", 6000, 0, cyc);
        check("gated_cycles_in_range", (cyc >= 2850 && cyc <= 2920), 1);
        drain("gated");
        gate_valid = 1'b0;

        // Slow ack on lane 0, then reset while the next request is pending.
        stuck[0]  = 1'b1;
        ack_delay = 20;
        slip_exp_q.push_back(7'h30);
        start_run();
        guard = 0;
        while (slip_exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("slow_ack_consumed", slip_exp_q.size(), 0);
        ack_mode = 0;
        guard    = 0;
        while (!slip_valid_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("second_req_valid", slip_valid_o, 1);
        check("second_req_dat", slip_dat_o, 7'h30);
        @(posedge clk); #1;
        rst_n_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("slip_rst_valid", slip_valid_o, 0);
        check("slip_rst_dat", slip_dat_o, 7'h00);
        check("slip_rst_busy", busy_o, 0);
        check("slip_rst_done", done_o, 0);
        check("slip_rst_fail", fail_o, 0);
        check("slip_rst_lock", lock_mask_o, 12'h000);
        check("slip_rst_failm", fail_mask_o, 12'h000);
        check("slip_rst_state", state_dbg_o, ST_IDLE);
        @(posedge clk); #1;
        rst_n_i  = 1'b1;
        start_i  = 1'b0;
        stuck[0] = 1'b0;
        ack_mode = 2;
        repeat (8) @(negedge clk);
        check("late_ack_valid", slip_valid_o, 0);
        check("late_ack_busy", busy_o, 0);
        check("late_ack_state", state_dbg_o, ST_IDLE);
        ack_mode = 0;
        repeat (3) @(negedge clk);
        check("final_slip_q_empty", slip_exp_q.size(), 0);
        check("final_res_q_empty", res_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
